// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-line fixed-priority interrupt controller (line 0 highest) with ISR-based nesting and EOI.
// int_req is registered from the pending/mask/ISR view; vector and ISR update the cycle after int_ack.
module irq_ctrl (
   input  logic       clk_i,
   input  logic       rst,
   input  logic [5:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   input  logic       bus_cyc,
   input  logic       bus_we,
   input  logic [7:0] irq_in,
   output logic       int_req,
   input  logic       int_ack,
   output logic [7:0] vec_out
);

   typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_e;

   state_e     state_q, state_d;
   logic [7:0] mask_q, mask_d;
   logic [7:0] edge_mode_q, edge_mode_d;
   logic [7:0] pend_edge_q, pend_edge_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] vbase_q, vbase_d;
   logic [7:0] irq_s_q, irq_s_d;
   logic [7:0] irq_p_q, irq_p_d;
   logic [7:0] vec_q, vec_d;
   logic [7:0] dout_q, dout_d;
   logic       spurious_q, spurious_d;
   logic [2:0] win_idx_q, win_idx_d;

   logic [7:0] pend, cand, qual, isr_low, wr_clr, ack_bit;
   logic [2:0] qual_idx;
   logic       wr, ack_hit;

   function automatic logic [2:0] lowest_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   // Priority view: a candidate must sit strictly above the lowest in-service line.
   // (isr & -isr) - 1 yields the bits below that line, or all ones when nothing is in service.
   always_comb begin
      wr       = bus_cyc & bus_we;
      pend     = (edge_mode_q & pend_edge_q) | (~edge_mode_q & irq_s_q);
      cand     = pend & mask_q;
      isr_low  = isr_q & (~isr_q + 8'd1);
      qual     = cand & (isr_low - 8'd1);
      qual_idx = lowest_idx(qual);
      ack_hit  = int_ack & (state_q == ST_REQ);
      ack_bit  = ack_hit ? (8'd1 << win_idx_q) : 8'd0;
      wr_clr   = (wr && addr == 6'd2) ? data_in : 8'd0;
   end

   always_comb begin
      irq_s_d     = irq_in;
      irq_p_d     = irq_s_q;
      mask_d      = (wr && addr == 6'd0) ? data_in : mask_q;
      edge_mode_d = (wr && addr == 6'd1) ? data_in : edge_mode_q;
      vbase_d     = (wr && addr == 6'd4) ? data_in : vbase_q;
      // A fresh edge beats a same-cycle write-clear or ack-clear.
      pend_edge_d = ((pend_edge_q & ~wr_clr & ~ack_bit) | (irq_s_q & ~irq_p_q)) & edge_mode_q;
      // EOI retires the lowest in-service bit before the ack adds its own.
      isr_d       = ((wr && addr == 6'd3) ? (isr_q & ~isr_low) : isr_q) | ack_bit;
      vec_d       = ack_hit ? {vbase_q[7:3], win_idx_q} : vec_q;

      spurious_d = spurious_q;
      if (int_ack && state_q == ST_IDLE) spurious_d = 1'b1;
      else if (wr && addr == 6'd5)       spurious_d = 1'b0;

      state_d   = state_q;
      win_idx_d = win_idx_q;
      if (state_q == ST_IDLE) begin
         if (qual != 8'd0) begin
            state_d   = ST_REQ;
            win_idx_d = qual_idx;
         end
      end else begin
         if (ack_hit || qual == 8'd0) state_d   = ST_IDLE;
         else                         win_idx_d = qual_idx;
      end

      dout_d = dout_q;
      if (bus_cyc) begin
         case (addr)
            6'd0:    dout_d = mask_q;
            6'd1:    dout_d = edge_mode_q;
            6'd2:    dout_d = pend;
            6'd3:    dout_d = isr_q;
            6'd4:    dout_d = vbase_q;
            6'd5:    dout_d = {state_q == ST_REQ, spurious_q, 3'b000, win_idx_q};
            default: dout_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mask_q      <= 8'h00;
         edge_mode_q <= 8'h00;
         pend_edge_q <= 8'h00;
         isr_q       <= 8'h00;
         vbase_q     <= 8'h00;
         irq_s_q     <= 8'h00;
         irq_p_q     <= 8'h00;
         vec_q       <= 8'h00;
         dout_q      <= 8'h00;
         spurious_q  <= 1'b0;
         win_idx_q   <= 3'd0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         edge_mode_q <= edge_mode_d;
         pend_edge_q <= pend_edge_d;
         isr_q       <= isr_d;
         vbase_q     <= vbase_d;
         irq_s_q     <= irq_s_d;
         irq_p_q     <= irq_p_d;
         vec_q       <= vec_d;
         dout_q      <= dout_d;
         spurious_q  <= spurious_d;
         win_idx_q   <= win_idx_d;
      end
   end

   assign int_req  = (state_q == ST_REQ);
   assign vec_out  = vec_q;
   assign data_out = dout_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios against fixed expectations, then random traffic against a cycle model.
module tb_irq_ctrl;

   logic       clk_i = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] addr = 6'd0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       bus_cyc = 1'b0;
   logic       bus_we = 1'b0;
   logic [7:0] irq_in = 8'h00;
   logic       int_req;
   logic       int_ack = 1'b0;
   logic [7:0] vec_out;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] cur_irq = 8'h00;

   // Reference state, advanced once per clock from the inputs applied that cycle.
   bit [7:0] m_mask, m_edge, m_pend, m_isr, m_vbase, m_s, m_p, m_vec, m_dout;
   bit       m_req, m_spur;
   bit [2:0] m_win;

   irq_ctrl dut (
      .clk_i(clk_i), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
      .bus_cyc(bus_cyc), .bus_we(bus_we), .irq_in(irq_in), .int_req(int_req),
      .int_ack(int_ack), .vec_out(vec_out)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_step(input bit r, input bit cyc, input bit we, input bit [5:0] a,
                             input bit [7:0] d, input bit [7:0] irq, input bit ack);
      int low_isr, best;
      bit [7:0] pv, n_isr, n_pend;
      bit acked, wrt;
      if (r) begin
         m_mask = 0; m_edge = 0; m_pend = 0; m_isr = 0; m_vbase = 0; m_s = 0; m_p = 0;
         m_vec = 0; m_dout = 0; m_req = 0; m_spur = 0; m_win = 0;
         return;
      end
      wrt = cyc && we;
      low_isr = 8;
      for (int i = 0; i < 8; i++) if (m_isr[i] && low_isr == 8) low_isr = i;
      for (int i = 0; i < 8; i++) pv[i] = m_edge[i] ? m_pend[i] : m_s[i];
      best = 8;
      for (int i = 0; i < 8; i++) if (best == 8 && pv[i] && m_mask[i] && i < low_isr) best = i;
      if (cyc) begin
         case (a)
            6'd0: m_dout = m_mask;
            6'd1: m_dout = m_edge;
            6'd2: m_dout = pv;
            6'd3: m_dout = m_isr;
            6'd4: m_dout = m_vbase;
            6'd5: m_dout = {m_req, m_spur, 3'b000, m_win};
            default: m_dout = 8'h00;
         endcase
      end
      acked = ack && m_req;
      n_isr = m_isr;
      if (wrt && a == 6'd3 && low_isr < 8) n_isr[low_isr] = 1'b0;
      if (acked) n_isr[m_win] = 1'b1;
      if (ack && !m_req) m_spur = 1'b1;
      else if (wrt && a == 6'd5) m_spur = 1'b0;
      if (acked) m_vec = {m_vbase[7:3], m_win};
      for (int i = 0; i < 8; i++) begin
         n_pend[i] = 1'b0;
         if (m_edge[i]) begin
            n_pend[i] = m_pend[i];
            if (wrt && a == 6'd2 && d[i]) n_pend[i] = 1'b0;
            if (acked && int'(m_win) == i) n_pend[i] = 1'b0;
            if (m_s[i] && !m_p[i]) n_pend[i] = 1'b1;
         end
      end
      if (acked) m_req = 1'b0;
      else if (best < 8) begin
         m_req = 1'b1;
         m_win = best[2:0];
      end else m_req = 1'b0;
      if (wrt && a == 6'd0) m_mask = d;
      if (wrt && a == 6'd1) m_edge = d;
      if (wrt && a == 6'd4) m_vbase = d;
      m_pend = n_pend;
      m_isr = n_isr;
      m_p = m_s;
      m_s = irq;
   endtask

   task automatic tick(input bit r, input bit cyc, input bit we, input bit [5:0] a,
                       input bit [7:0] d, input bit [7:0] irq, input bit ack);
      @(negedge clk_i);
      rst = r; bus_cyc = cyc; bus_we = we; addr = a; data_in = d; irq_in = irq; int_ack = ack;
      @(posedge clk_i);
      model_step(r, cyc, we, a, d, irq, ack);
      #1;
   endtask

   task automatic idle();                         tick(0, 0, 0, 6'd0, 8'h00, cur_irq, 0); endtask
   task automatic ack_cyc();                      tick(0, 0, 0, 6'd0, 8'h00, cur_irq, 1); endtask
   task automatic wr_reg(input bit [5:0] a, input bit [7:0] d); tick(0, 1, 1, a, d, cur_irq, 0); endtask
   task automatic rd_reg(input bit [5:0] a);      tick(0, 1, 0, a, 8'h00, cur_irq, 0); endtask

   task automatic test_reset();
      tick(1, 0, 0, 6'd0, 8'h00, 8'h00, 0);
      tick(1, 0, 0, 6'd0, 8'h00, 8'h00, 0);
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL reset_int_req got %b want 0", int_req); end
      n_cmp++; if (vec_out !== 8'h00) begin n_err++; $display("FAIL reset_vec got %h want 00", vec_out); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", data_out); end
      rd_reg(6'd5);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_status got %h want 00", data_out); end
   endtask

   task automatic test_edge_line();
      wr_reg(6'd0, 8'h02); wr_reg(6'd1, 8'h02); wr_reg(6'd4, 8'h40); idle();
      cur_irq = 8'h02; idle();
      cur_irq = 8'h00; idle();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL edge_early got %b want 0", int_req); end
      idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL edge_latency3 got %b want 1", int_req); end
      ack_cyc();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL edge_ack_drop got %b want 0", int_req); end
      n_cmp++; if (vec_out !== 8'h41) begin n_err++; $display("FAIL edge_vec got %h want 41", vec_out); end
      rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h02) begin n_err++; $display("FAIL edge_isr got %h want 02", data_out); end
      rd_reg(6'd2);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL edge_pend got %h want 00", data_out); end
      wr_reg(6'd3, 8'h00); rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL edge_eoi got %h want 00", data_out); end
   endtask

   task automatic test_level_line();
      wr_reg(6'd1, 8'h00); wr_reg(6'd0, 8'h20);
      cur_irq = 8'h20; idle();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_early got %b want 0", int_req); end
      idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL level_latency2 got %b want 1", int_req); end
      ack_cyc();
      n_cmp++; if (vec_out !== 8'h45) begin n_err++; $display("FAIL level_vec got %h want 45", vec_out); end
      for (int i = 0; i < 3; i++) begin
         idle();
         n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_blocked got %b want 0", int_req); end
      end
      rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h20) begin n_err++; $display("FAIL level_isr got %h want 20", data_out); end
      wr_reg(6'd3, 8'h00);
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL level_eoi_edge got %b want 0", int_req); end
      idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL level_rereq got %b want 1", int_req); end
   endtask

   task automatic test_nesting();
      ack_cyc();
      wr_reg(6'd0, 8'h24);
      cur_irq = 8'h24; idle(); idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL nest_req got %b want 1", int_req); end
      rd_reg(6'd5);
      n_cmp++; if (data_out !== 8'h82) begin n_err++; $display("FAIL nest_status got %h want 82", data_out); end
      ack_cyc();
      n_cmp++; if (vec_out !== 8'h42) begin n_err++; $display("FAIL nest_vec got %h want 42", vec_out); end
      cur_irq = 8'h20; rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h24) begin n_err++; $display("FAIL nest_isr2 got %h want 24", data_out); end
      wr_reg(6'd3, 8'h00); rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h20) begin n_err++; $display("FAIL nest_eoi1 got %h want 20", data_out); end
      wr_reg(6'd3, 8'h00); rd_reg(6'd3);
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL nest_eoi2 got %h want 00", data_out); end
      // Line 5 now re-requests; dropping it withdraws the request without an ack.
      cur_irq = 8'h00; idle(); idle();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL nest_withdraw got %b want 0", int_req); end
   endtask

   task automatic test_two_pending();
      wr_reg(6'd0, 8'h48); wr_reg(6'd1, 8'h48);
      cur_irq = 8'h48; idle();
      cur_irq = 8'h00; idle(); idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL two_req got %b want 1", int_req); end
      ack_cyc();
      n_cmp++; if (vec_out !== 8'h43) begin n_err++; $display("FAIL two_vec3 got %h want 43", vec_out); end
      idle();
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL two_blocked got %b want 0", int_req); end
      rd_reg(6'd2);
      n_cmp++; if (data_out !== 8'h40) begin n_err++; $display("FAIL two_pend got %h want 40", data_out); end
      wr_reg(6'd3, 8'h00); idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL two_req6 got %b want 1", int_req); end
      ack_cyc();
      n_cmp++; if (vec_out !== 8'h46) begin n_err++; $display("FAIL two_vec6 got %h want 46", vec_out); end
      wr_reg(6'd3, 8'h00);
   endtask

   task automatic test_spurious();
      idle();
      ack_cyc();
      n_cmp++; if (vec_out !== 8'h46) begin n_err++; $display("FAIL spur_vec got %h want 46", vec_out); end
      rd_reg(6'd5);
      n_cmp++; if (data_out[7:6] !== 2'b01) begin n_err++; $display("FAIL spur_set got %b want 01", data_out[7:6]); end
      wr_reg(6'd5, 8'h00); rd_reg(6'd5);
      n_cmp++; if (data_out[6] !== 1'b0) begin n_err++; $display("FAIL spur_clear got %b want 0", data_out[6]); end
   endtask

   task automatic test_reset_mid();
      wr_reg(6'd1, 8'h00); wr_reg(6'd4, 8'h80); wr_reg(6'd0, 8'h01);
      cur_irq = 8'h01; idle(); idle();
      n_cmp++; if (int_req !== 1'b1) begin n_err++; $display("FAIL rstmid_req got %b want 1", int_req); end
      tick(1, 0, 0, 6'd0, 8'h00, cur_irq, 1);
      n_cmp++; if (int_req !== 1'b0) begin n_err++; $display("FAIL rstmid_int_req got %b want 0", int_req); end
      n_cmp++; if (vec_out !== 8'h00) begin n_err++; $display("FAIL rstmid_vec got %h want 00", vec_out); end
      n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_dout got %h want 00", data_out); end
      cur_irq = 8'h00;
      for (int a = 0; a < 6; a++) begin
         rd_reg(6'(a));
         n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_reg%0d got %h want 00", a, data_out); end
      end
   endtask

   task automatic test_random();
      bit cyc, we, ack, r;
      bit [5:0] a;
      tick(1, 0, 0, 6'd0, 8'h00, 8'h00, 0);
      cur_irq = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         r   = ($urandom_range(0, 499) == 0);
         cyc = ($urandom_range(0, 9) < 4);
         we  = $urandom_range(0, 1);
         a   = 6'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ (8'($urandom) & 8'($urandom));
         ack = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
         tick(r, cyc, we, a, 8'($urandom), cur_irq, ack);
         n_cmp++; if (int_req !== m_req) begin n_err++; $display("FAIL rnd_int_req cyc %0d got %b want %b", c, int_req, m_req); end
         n_cmp++; if (vec_out !== m_vec) begin n_err++; $display("FAIL rnd_vec cyc %0d got %h want %h", c, vec_out, m_vec); end
         n_cmp++; if (data_out !== m_dout) begin n_err++; $display("FAIL rnd_dout cyc %0d got %h want %h", c, data_out, m_dout); end
      end
   endtask

   initial begin
      test_reset();
      test_edge_line();
      test_level_line();
      test_nesting();
      test_two_pending();
      test_spurious();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
